// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv
//   Multi-cycle multiply/divide unit with the architectural HI/LO registers.
//   It sits in EX behind the ID/EX register. MULT/MULTU take 5 cycles and
//   DIV/DIVU take 10 cycles. MTHI/MTLO write in one cycle. MFHI/MFLO read
//   hi/lo directly.
//
// Ports
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous reset, active low
//   start   in   1   mul/div/mt instruction valid in EX this cycle
//   op      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   rs_val  in  32   multiplicand / dividend / MT source
//   rt_val  in  32   multiplier / divisor
//   busy    out  1   an operation is in flight (hazard unit stalls ID on it)
//   done    out  1   one-cycle pulse in the first cycle new HI/LO are visible
//   hi      out 32   HI register
//   lo      out 32   LO register
// ----------------------------------------------------------------------------
module ex_muldiv (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] MUL_LAT = 4'd5;
   localparam logic [3:0] DIV_LAT = 4'd10;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [1:0]  op_q;   // only mul/div ops are latched; bit 1 = divide
   logic [31:0] a_q;
   logic [31:0] b_q;

   // ------------------------------------------------------------------------
   // Result datapath, driven only by the latched operands. The registers
   // take its value on the single edge where the counter expires, so hi/lo
   // never show a partial result.
   // ------------------------------------------------------------------------
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        div_sgn;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_div;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_wr;

   always_comb begin
      // Sign-extending both factors to 64 bits makes the low 64 bits of
      // the product equal to the two's-complement signed product.
      prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u = {32'd0, a_q} * {32'd0, b_q};

      // Signed divide is done on magnitudes. 0x80000000 / -1 then comes
      // out as 0x80000000 rem 0 naturally: the magnitude 2^31 fits
      // unsigned, and negating it wraps back to itself.
      div_sgn = (op_q == OP_DIV[1:0]);
      a_neg   = div_sgn & a_q[31];
      b_neg   = div_sgn & b_q[31];
      a_mag   = a_neg ? (32'd0 - a_q) : a_q;
      b_mag   = b_neg ? (32'd0 - b_q) : b_q;
      // A zero divisor never writes back. Steering it to 1 keeps the
      // divider from evaluating x/0.
      b_div   = (b_q == 32'd0) ? 32'd1 : b_mag;
      q_mag   = a_mag / b_div;
      r_mag   = a_mag % b_div;
      quo     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem     = a_neg ? (32'd0 - r_mag) : r_mag;  // remainder follows dividend

      res_hi  = 32'd0;
      res_lo  = 32'd0;
      res_wr  = 1'b1;
      case (op_q)
         OP_MULT[1:0]: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_MULTU[1:0]: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         default: begin
            res_hi = rem;
            res_lo = quo;
            res_wr = (b_q != 32'd0);
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control FSM and architectural registers. The counter is loaded with the
   // full latency and the result lands on the 1->0 edge. done therefore
   // rises in the same cycle busy falls, and a new start is accepted in
   // that cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         op_q  <= 2'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        op_q  <= op[1:0];
                        a_q   <= rs_val;
                        b_q   <= rt_val;
                        cnt   <= op[1] ? DIV_LAT : MUL_LAT;
                        busy  <= 1'b1;
                        state <= RUN;
                     end
                     OP_MTHI: hi <= rs_val;
                     OP_MTLO: lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               // start is deliberately not looked at here. A stray issue
               // while busy must not disturb the operation in flight.
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  if (res_wr) begin
                     hi <= res_hi;
                     lo <= res_lo;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv
//   Bench for ex_muldiv. A cycle-level reference model tracks expected
//   busy/done/hi/lo from the operation's completion time stamp and plain
//   64-bit arithmetic. One compare process checks the DUT against the model
//   on every falling edge. Directed sequences pin the model with literal
//   expectations. A random phase follows.
// ----------------------------------------------------------------------------
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   ex_muldiv dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl, output bit wr);
      longint      sa, sb, q, r;
      logic [63:0] p;
      rh = 32'd0;
      rl = 32'd0;
      wr = 1'b1;
      case (o)
         3'd0: begin
            p  = longint'($signed(a)) * longint'($signed(b));
            rh = p[63:32];
            rl = p[31:0];
         end
         3'd1: begin
            p  = {32'd0, a} * {32'd0, b};
            rh = p[63:32];
            rl = p[31:0];
         end
         3'd2: begin
            if (b == 32'd0) wr = 1'b0;
            else begin
               sa = longint'($signed(a));
               sb = longint'($signed(b));
               q  = sa / sb;
               r  = sa % sb;
               p  = q;
               rl = p[31:0];
               p  = r;
               rh = p[31:0];
            end
         end
         default: begin
            if (b == 32'd0) wr = 1'b0;
            else begin
               rl = a / b;
               rh = a % b;
            end
         end
      endcase
   endfunction

   int          cyc = 0;
   int          m_end = 0;
   bit          m_pend = 0;
   bit          m_busy = 0;
   bit          m_done = 0;
   bit          m_wr = 0;
   logic [31:0] m_hi = 0, m_lo = 0, m_rhi = 0, m_rlo = 0;

   // cyc is the index of the cycle just entered. An op accepted at the end
   // of cycle c occupies c+1 .. c+lat and its result appears in c+lat+1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend = 0; m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; cyc = 0;
      end else begin
         cyc++;
         m_done = 0;
         if (m_pend) begin
            if (cyc == m_end) begin
               m_pend = 0;
               m_done = 1;
               if (m_wr) begin
                  m_hi = m_rhi;
                  m_lo = m_rlo;
               end
            end
         end else if (start) begin
            if (op <= 3'd3) begin
               calc(op, rs_val, rt_val, m_rhi, m_rlo, m_wr);
               m_pend = 1;
               m_end  = cyc + (op[1] ? 10 : 5);
            end else if (op == 3'd4) m_hi = rs_val;
            else if (op == 3'd5) m_lo = rs_val;
         end
         m_busy = m_pend;
      end
   end

   always @(negedge clk) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
   end

   // ---------------- directed helpers ----------------
   // Issues one op for one cycle, optionally injects a stray MULT while busy,
   // then waits for done and checks busy length and the result literally.
   task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int eb, input int inj);
      int nb;
      bit seen;
      @(posedge clk); #1;
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      start = 1'b0;
      nb = 0;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) seen = 1;
         if (i == inj) begin
            start = 1'b1; op = 3'd0; rs_val = 32'd100; rt_val = 32'd100;
         end else start = 1'b0;
      end
      start = 1'b0;
      chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
      chk({nm, "_busy_cycles"}, nb, eb);
      chk({nm, "_hi"}, hi, eh);
      chk({nm, "_lo"}, lo, el);
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int nd;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mult_neg", 3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, -1);
      run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, -1);
      run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, -1);
      run_op("divu_zero", 3'd3, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, -1);
      run_op("mult_ignore", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1);

      // MTHI: single-cycle write, no busy
      @(posedge clk); #1;
      start = 1'b1; op = 3'd4; rs_val = 32'h12345678; rt_val = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      chk("mthi_done", {31'd0, done}, 32'd0);

      // DIV aborted by an asynchronous reset in cycle T+4
      @(posedge clk); #1;
      start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      #1 rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("arst_no_done", nd, 0);
      chk("arst_hi_after", hi, 32'd0);

      run_op("mult_after_rst", 3'd0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5, -1);
      run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, -1);

      // random phase: starts may land while busy and are then ignored
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         start  = ($urandom_range(0, 2) == 0);
         op     = 3'($urandom_range(0, 7));
         rs_val = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 7))
            0:       rt_val = 32'd0;
            1:       rt_val = 32'hFFFFFFFF;
            2:       rt_val = 32'($urandom_range(1, 9));
            default: rt_val = $urandom;
         endcase
      end
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
